// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one serial transmitter between NUM_REQ byte
// requesters. It pulses start and ack, waits for done under a watchdog, then idles for a gap.
module tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_stop2,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   req_done,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 tx_stop2,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] owner;
  logic [GW-1:0] winner;
  logic          any_req;
  logic [7:0]    cnt;
  int            cand;

  // Walk the candidates from farthest to nearest so the nearest valid one
  // after last_grant overwrites the rest.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    winner  = last_grant;
    any_req = 1'b0;
    cand    = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = int'(last_grant) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req_valid[GW'(cand)]) begin
        winner  = GW'(cand);
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= GW'(NUM_REQ - 1);
      owner       <= '0;
      cnt         <= '0;
      req_ack     <= '0;
      req_done    <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      tx_stop2    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values; the defaults below make the
      // ack, done, start and error outputs single-cycle pulses.
      req_ack     <= '0;
      req_done    <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (en && any_req) begin
            state           <= SEND;
            busy            <= 1'b1;
            tx_start        <= 1'b1;
            req_ack[winner] <= 1'b1;
            owner           <= winner;
            last_grant      <= winner;
            tx_data         <= req_data[{winner, 3'b000} +: 8];
            tx_stop2        <= req_stop2[winner];
          end
        end
        SEND: begin
          cnt   <= '0;
          state <= WAIT;
        end
        // WAIT lasts at most TIMEOUT cycles. A done in the last one still wins over the watchdog.
        WAIT: begin
          if (tx_done) begin
            req_done[owner] <= 1'b1;
            cnt             <= '0;
            state           <= GAP;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == 8'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter. It has a transmitter model that answers a start with
// done after 11 cycles (one stop bit) or 12 cycles (two stop bits).
module tb_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_stop2 = '0;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   req_done;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_stop2;
  logic           tx_done;
  logic           busy;
  logic           timeout_err;

  logic model_done = 1'b0;
  logic stray_done = 1'b0;
  logic model_on = 1'b1;
  int   pend = 0;
  int   checks = 0;
  int   errors = 0;

  assign tx_done = model_done | stray_done;

  always #5 clk = ~clk;

  tx_arbiter #(.NUM_REQ(N), .TIMEOUT(16), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_stop2(req_stop2),
    .req_ack(req_ack), .req_done(req_done),
    .tx_start(tx_start), .tx_data(tx_data), .tx_stop2(tx_stop2),
    .tx_done(tx_done), .busy(busy), .timeout_err(timeout_err)
  );

  // Transmitter model. If it sees start in cycle S, it drives done during cycle S+11 or S+12.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (!rst_n) pend = 0;
    else if (tx_start && model_on) pend = tx_stop2 ? 12 : 11;
    else if (pend > 0) begin
      pend--;
      if (pend == 0) model_done = 1'b1;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Call this in an IDLE cycle that already has the request set up. It returns in the next IDLE cycle.
  task automatic do_xfer(input string tag, input int who, input logic [7:0] dat, input logic s2);
    int         lat;
    logic [3:0] oh;
    lat = s2 ? 12 : 11;
    oh  = 4'(1 << who);
    tick;
    check({tag, " start"}, tx_start, 1);
    check({tag, " ack"}, req_ack, oh);
    check({tag, " data"}, tx_data, dat);
    check({tag, " stop2"}, tx_stop2, s2);
    check({tag, " busy send"}, busy, 1);
    repeat (lat - 1) tick;
    check({tag, " done early"}, tx_done, 0);
    tick;
    check({tag, " done"}, tx_done, 1);
    check({tag, " data held"}, tx_data, dat);
    check({tag, " req_done wait"}, req_done, 0);
    tick;
    check({tag, " req_done"}, req_done, oh);
    check({tag, " busy gap"}, busy, 1);
    check({tag, " start gap"}, tx_start, 0);
    tick;
    check({tag, " busy idle"}, busy, 0);
    check({tag, " req_done idle"}, req_done, 0);
  endtask

  initial begin
    // Reset state
    tick;
    tick;
    check("rst start", tx_start, 0);
    check("rst ack", req_ack, 0);
    check("rst req_done", req_done, 0);
    check("rst busy", busy, 0);
    check("rst data", tx_data, 0);
    check("rst stop2", tx_stop2, 0);
    check("rst err", timeout_err, 0);
    rst_n = 1'b1;
    tick;

    // 1: single request with one stop bit
    en             = 1'b1;
    req_data[7:0]  = 8'hA5;
    req_valid      = 4'b0001;
    do_xfer("t1", 0, 8'hA5, 1'b0);
    req_valid = '0;
    tick;
    check("t1 stays idle", busy, 0);

    // 2: round-robin rotation starting fresh from reset
    rst_n = 1'b0;
    tick;
    rst_n     = 1'b1;
    req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
    req_valid = 4'b1111;
    do_xfer("t2 r0", 0, 8'h10, 1'b0);
    do_xfer("t2 r1", 1, 8'h21, 1'b0);
    do_xfer("t2 r2", 2, 8'h32, 1'b0);
    do_xfer("t2 r3", 3, 8'h43, 1'b0);
    do_xfer("t2 r0b", 0, 8'h10, 1'b0);

    // 3: wrap-around. Set last_grant = 2, then requesters 0 and 1 ask.
    req_valid = 4'b0100;
    do_xfer("t3 r2", 2, 8'h32, 1'b0);
    req_valid = 4'b0011;
    req_stop2 = 4'b0010;
    do_xfer("t3 r0", 0, 8'h10, 1'b0);
    do_xfer("t3 r1", 1, 8'h21, 1'b1);
    req_valid = '0;
    req_stop2 = '0;

    // 4: watchdog. WAIT spans S+1..S+16 and the error pulses in S+17.
    model_on      = 1'b0;
    req_data[7:0] = 8'h5A;
    req_valid     = 4'b0001;
    tick;
    req_valid = '0;
    check("t4 start", tx_start, 1);
    check("t4 ack", req_ack, 4'b0001);
    check("t4 data", tx_data, 8'h5A);
    repeat (16) tick;
    check("t4 err early", timeout_err, 0);
    check("t4 busy wait", busy, 1);
    tick;
    check("t4 err", timeout_err, 1);
    check("t4 no req_done", req_done, 0);
    tick;
    check("t4 err clear", timeout_err, 0);
    check("t4 idle", busy, 0);
    // A done in the last WAIT cycle beats the watchdog.
    req_valid = 4'b0001;
    tick;
    req_valid = '0;
    check("t4 tie start", tx_start, 1);
    repeat (16) tick;
    stray_done = 1'b1;
    tick;
    stray_done = 1'b0;
    check("t4 tie req_done", req_done, 4'b0001);
    check("t4 tie no err", timeout_err, 0);
    tick;
    model_on  = 1'b1;
    req_valid = 4'b0010;
    do_xfer("t4 next", 1, 8'h21, 1'b0);
    req_valid = '0;

    // 5: enable gating, a stray done while IDLE, and a two-stop-bit byte
    en             = 1'b0;
    req_data[23:16] = 8'hC3;
    req_stop2      = 4'b0100;
    req_valid      = 4'b0100;
    tick;
    stray_done = 1'b1;
    tick;
    stray_done = 1'b0;
    check("t5 no ack", req_ack, 0);
    check("t5 no start", tx_start, 0);
    check("t5 not busy", busy, 0);
    tick;
    check("t5 stray ignored", req_done, 0);
    check("t5 no err", timeout_err, 0);
    check("t5 still idle", busy, 0);
    en = 1'b1;
    do_xfer("t5", 2, 8'hC3, 1'b1);
    req_valid = '0;
    req_stop2 = '0;

    // 6: reset while in WAIT
    req_data[7:0] = 8'h77;
    req_valid     = 4'b0001;
    tick;
    req_valid = '0;
    check("t6 start", tx_start, 1);
    repeat (5) tick;
    check("t6 busy wait", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6 async busy", busy, 0);
    check("t6 async data", tx_data, 0);
    check("t6 async start", tx_start, 0);
    check("t6 async ack", req_ack, 0);
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      check("t6 no req_done", req_done, 0);
    end
    check("t6 no err", timeout_err, 0);
    req_valid = 4'b0011;
    do_xfer("t6 prio", 0, 8'h77, 1'b0);
    // Reset during SEND drops tx_start mid-pulse.
    tick;
    check("t6 send start", tx_start, 1);
    check("t6 send ack", req_ack, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("t6 drop start", tx_start, 0);
    check("t6 drop ack", req_ack, 0);
    tick;
    rst_n     = 1'b1;
    req_valid = '0;
    tick;
    check("t6 final idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
